// File: rtl/bcd_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_score_keeper                                              |
// | Brief    : Six-digit BCD score register. Adds 0-9 points per request     |
// |            by rippling the carry one digit per clock, and saturates at   |
// |            999999 with a sticky overflow flag. Adds are refused while    |
// |            frozen. Define HIGH_SCORE_EN to keep a high-score record that |
// |            survives new-game clears.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_score_keeper (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    input  logic        add,
    input  logic [3:0]  amount,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  bcd0,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd4,
    output logic [3:0]  bcd5,
    output logic [23:0] hi_bcd,
    output logic        new_record
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    localparam logic [23:0] C_SCORE_MAX  = 24'h999999;
    localparam logic [3:0]  C_AMOUNT_MAX = 4'd9;
    localparam logic [2:0]  C_TOP_IDX    = 3'd5;

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_score;
    logic [23:0] w_score_next;
    logic [3:0]  r_carry;
    logic [3:0]  w_carry_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic        r_overflow;
    logic        w_overflow_next;

    logic [4:0]  w_base;
    logic [3:0]  w_digit;
    logic [4:0]  w_sum;
    logic [3:0]  w_digit_wrap;

    // Digit currently being worked on and its sum with the pending carry.
    // The carry register holds the clamped amount on the first step and
    // 0/1 afterwards, so the sum never exceeds 18.
    assign w_base       = {r_idx, 2'b00};
    assign w_digit      = r_score[w_base +: 4];
    assign w_sum        = {1'b0, w_digit} + {1'b0, r_carry};
    // Modulo-16 subtraction gives the right result for sums 10..18.
    assign w_digit_wrap = w_sum[3:0] - 4'd10;

    // Next-state logic: accept in IDLE, ripple one digit per ADD cycle,
    // force all nines in SAT.
    always_comb begin
        w_state_next    = r_state;
        w_score_next    = r_score;
        w_carry_next    = r_carry;
        w_idx_next      = r_idx;
        w_overflow_next = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if (add && !freeze) begin
                    if (r_overflow) begin
                        // Score is already pinned at 999999; rippling would
                        // only flash intermediate zeros on the display.
                        w_state_next = ST_SAT;
                    end else begin
                        w_carry_next = (amount > C_AMOUNT_MAX) ? C_AMOUNT_MAX : amount;
                        w_idx_next   = 3'd0;
                        w_state_next = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (w_sum >= 5'd10) begin
                    w_score_next[w_base +: 4] = w_digit_wrap;
                    w_carry_next              = 4'd1;
                    if (r_idx == C_TOP_IDX) begin
                        w_state_next = ST_SAT;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_score_next[w_base +: 4] = w_sum[3:0];
                    w_carry_next              = 4'd0;
                    w_state_next              = ST_IDLE;
                end
            end
            ST_SAT: begin
                w_score_next    = C_SCORE_MAX;
                w_overflow_next = 1'b1;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset and new-game clear both abort any addition.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= ST_IDLE;
            r_score    <= '0;
            r_carry    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_score    <= w_score_next;
            r_carry    <= w_carry_next;
            r_idx      <= w_idx_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;
    assign bcd0     = r_score[3:0];
    assign bcd1     = r_score[7:4];
    assign bcd2     = r_score[11:8];
    assign bcd3     = r_score[15:12];
    assign bcd4     = r_score[19:16];
    assign bcd5     = r_score[23:20];

`ifdef HIGH_SCORE_EN
    logic        r_freeze_d;
    logic        r_cmp_pend;
    logic [23:0] r_hi;
    logic        r_new_record;
    logic        w_cmp_req;

    // A compare is wanted on the freeze rising edge, and keeps being wanted
    // while freeze stays high until the adder is idle.
    assign w_cmp_req = freeze && (!r_freeze_d || r_cmp_pend);

    // High-score capture. Valid BCD digits order the same way as the packed
    // binary vector, so a plain magnitude compare is an MSD-first compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freeze_d   <= 1'b0;
            r_cmp_pend   <= 1'b0;
            r_hi         <= '0;
            r_new_record <= 1'b0;
        end else begin
            r_freeze_d <= freeze;
            if (clear) begin
                r_cmp_pend   <= 1'b0;
                r_new_record <= 1'b0;
            end else if (w_cmp_req) begin
                if (r_state == ST_IDLE) begin
                    r_cmp_pend <= 1'b0;
                    if (r_score > r_hi) begin
                        r_hi         <= r_score;
                        r_new_record <= 1'b1;
                    end
                end else begin
                    r_cmp_pend <= 1'b1;
                end
            end else begin
                r_cmp_pend <= 1'b0;
            end
        end
    end

    assign hi_bcd     = r_hi;
    assign new_record = r_new_record;
`else
    assign hi_bcd     = '0;
    assign new_record = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_score_keeper                                           |
// | Brief    : Scoreboard bench for bcd_score_keeper with an integer-based   |
// |            reference model, directed scenarios and random traffic.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bcd_score_keeper;

`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, freeze, add;
    logic [3:0]  amount;
    logic        busy, overflow, new_record;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4, bcd5;
    logic [23:0] hi_bcd;

    bcd_score_keeper dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .freeze     (freeze),
        .add        (add),
        .amount     (amount),
        .busy       (busy),
        .overflow   (overflow),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .bcd3       (bcd3),
        .bcd4       (bcd4),
        .bcd5       (bcd5),
        .hi_bcd     (hi_bcd),
        .new_record (new_record)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] score;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          fails  = 0;

    // Reference model state, valid just after each rising edge.
    int          m_score = 0;
    bit          m_ovf   = 1'b0;
    int          m_rem   = 0;
    int          m_hi    = 0;
    bit          m_rec   = 1'b0;
    bit          m_fprev = 1'b0;
    bit          m_pend  = 1'b0;
    bit          abort   = 1'b0;
    bit          fz      = 1'b0;
    logic [23:0] preload_val;

    wire [23:0] score_vec = {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Busy cycles = 1 + number of digit positions that receive a carry.
    function automatic int latency(input int old, input int a);
        int l;
        int p;
        if (old + a > 999999) return 7;
        l = 1;
        p = 10;
        for (int i = 0; i < 5; i++) begin
            if ((old % p) + a >= p) l++;
            p = p * 10;
        end
        return l;
    endfunction

    // Apply the effect of one clock edge with the given inputs to the model.
    task automatic model_edge(input logic r, input logic c, input logic f,
                              input logic a, input logic [3:0] amt);
        bit   idle_before;
        int   a9;
        exp_t e;
        idle_before = (m_rem == 0);
        if (r || c) begin
            if (m_rem > 0) abort = 1'b1;
            q.delete();
            m_score = 0;
            m_ovf   = 1'b0;
            m_rem   = 0;
            m_rec   = 1'b0;
            m_pend  = 1'b0;
            m_fprev = r ? 1'b0 : f;
            if (r) m_hi = 0;
        end else begin
            if (HS) begin
                if (f && (!m_fprev || m_pend)) begin
                    if (idle_before) begin
                        m_pend = 1'b0;
                        if (m_score > m_hi) begin
                            m_hi  = m_score;
                            m_rec = 1'b1;
                        end
                    end else begin
                        m_pend = 1'b1;
                    end
                end else begin
                    m_pend = 1'b0;
                end
            end
            m_fprev = f;
            if (m_rem > 0) m_rem--;
            if (idle_before && a && !f) begin
                a9 = (amt > 9) ? 9 : int'(amt);
                if (m_ovf) begin
                    e.lat = 1;
                end else begin
                    e.lat = latency(m_score, a9);
                    if (m_score + a9 > 999999) begin
                        m_score = 999999;
                        m_ovf   = 1'b1;
                    end else begin
                        m_score = m_score + a9;
                    end
                end
                e.score = to_bcd(m_score);
                e.ovf   = m_ovf;
                m_rem   = e.lat;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic f,
                         input logic a, input logic [3:0] amt);
        reset  = r;
        clear  = c;
        freeze = f;
        add    = a;
        amount = amt;
        @(posedge clk);
        #1;
        model_edge(r, c, f, a, amt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, fz, 1'b0, 4'd0);
    endtask

    task automatic add_pts(input int v);
        cycle(1'b0, 1'b0, fz, 1'b1, 4'(v));
        idle(8);
    endtask

    task automatic build(input int target);
        int t;
        t = target;
        while (t > 0) begin
            add_pts((t > 9) ? 9 : t);
            t = t - ((t > 9) ? 9 : t);
        end
    endtask

    // Jump the score register to a chosen value while the adder is idle.
    task automatic preload(input int v);
        reset  = 1'b0;
        clear  = 1'b0;
        freeze = 1'b0;
        add    = 1'b0;
        amount = 4'd0;
        preload_val = to_bcd(v);
        force dut.r_score = preload_val;
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        release dut.r_score;
        m_score = v;
    endtask

    task automatic rand_cycle(input bit allow_rst);
        logic r, c, a;
        logic [3:0] amt;
        r   = allow_rst && ($urandom_range(0, 499) == 0);
        c   = ($urandom_range(0, allow_rst ? 149 : 399) == 0);
        if ($urandom_range(0, 24) == 0) fz = ~fz;
        a   = ($urandom_range(0, 2) == 0);
        amt = 4'($urandom_range(0, 15));
        cycle(r, c, fz, a, amt);
    endtask

    // Monitor: pops the scoreboard whenever an addition finishes.
    int busy_cnt  = 0;
    bit busy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busy_cnt++;
            if (busy_cnt == 20) chk("busy_timeout", 32'(busy_cnt), 32'd7);
        end
        if (busy_prev && busy === 1'b0) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("score", {8'h0, score_vec}, {8'h0, e.score});
                chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
                chk("latency", 32'(busy_cnt), 32'(e.lat));
            end else if (abort) begin
                abort = 1'b0;
            end else begin
                chk("unexpected_done", 32'd1, 32'd0);
            end
        end
        if (busy === 1'b0) begin
            busy_cnt = 0;
            chk("hi_bcd", {8'h0, hi_bcd}, {8'h0, to_bcd(m_hi)});
            chk("new_record", {31'h0, new_record}, {31'h0, m_rec});
        end
        chk("digit_range", {31'h0, (bcd0 <= 9) && (bcd1 <= 9) && (bcd2 <= 9) &&
                                   (bcd3 <= 9) && (bcd4 <= 9) && (bcd5 <= 9)}, 32'd1);
        busy_prev = (busy === 1'b1);
    end

    initial begin
        // Reset values
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        chk("rst_score", {8'h0, score_vec}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_overflow", {31'h0, overflow}, 32'd0);
        chk("rst_hi", {8'h0, hi_bcd}, 32'h0);
        chk("rst_record", {31'h0, new_record}, 32'd0);

        // Single-cycle add
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        chk("add7_busy", {31'h0, busy}, 32'd1);
        idle(1);
        chk("add7_done", {31'h0, busy}, 32'd0);
        chk("add7_score", {8'h0, score_vec}, 32'h000007);

        // Digit-serial timing: 95 + 8
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        build(95);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        idle(1);
        chk("k1_bcd0", {28'h0, bcd0}, 32'd3);
        chk("k1_bcd1", {28'h0, bcd1}, 32'd9);
        idle(1);
        chk("k2_bcd1", {28'h0, bcd1}, 32'd0);
        chk("k2_bcd2", {28'h0, bcd2}, 32'd0);
        idle(1);
        chk("k3_bcd2", {28'h0, bcd2}, 32'd1);
        chk("k3_busy", {31'h0, busy}, 32'd0);
        idle(2);

        // Freeze raised mid-carry on 99 + 1
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        build(99);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        fz = 1'b1;
        idle(7);
        chk("frz_score", {8'h0, score_vec}, 32'h000100);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
        chk("frz_busy", {31'h0, busy}, 32'd0);
        idle(3);
        chk("frz_hold", {8'h0, score_vec}, 32'h000100);
        fz = 1'b0;
        idle(2);

        // Clamp, add while busy, clear during ADD
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        idle(3);
        chk("clamp9", {8'h0, score_vec}, 32'h000009);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        idle(4);
        chk("busy_drop", {8'h0, score_vec}, 32'h000018);
        build(81);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("clr_score", {8'h0, score_vec}, 32'h0);
        chk("clr_busy", {31'h0, busy}, 32'd0);
        idle(3);

        // Saturation from 999998
        preload(999998);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        idle(9);
        chk("sat_score", {8'h0, score_vec}, 32'h999999);
        chk("sat_ovf", {31'h0, overflow}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        idle(3);
        chk("sat_hold", {8'h0, score_vec}, 32'h999999);

        // High-score record
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        build(42);
        fz = 1'b1;
        idle(3);
        chk("hs_hi42", {8'h0, hi_bcd}, HS ? 32'h000042 : 32'h0);
        chk("hs_rec1", {31'h0, new_record}, {31'h0, HS});
        fz = 1'b0;
        idle(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        build(10);
        fz = 1'b1;
        idle(3);
        chk("hs_keep", {8'h0, hi_bcd}, HS ? 32'h000042 : 32'h0);
        chk("hs_rec0", {31'h0, new_record}, 32'd0);
        fz = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(1);
        chk("hs_reset", {8'h0, hi_bcd}, 32'h0);

        // Random traffic from zero, then near the saturation point
        for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
        fz = 1'b0;
        idle(10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        preload(999900);
        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
        fz = 1'b0;
        idle(10);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
